// File: rtl/lcd_write_arbiter_if.sv
// Requester and LCD pin bundle for lcd_write_arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface lcd_write_arbiter_if;
   logic       iREQ0;
   logic       iREQ1;
   logic       iRS0;
   logic       iRS1;
   logic [7:0] iDATA0;
   logic [7:0] iDATA1;
   logic       oACK0;
   logic       oACK1;
   logic       oREADY;
   logic [7:0] oLCD_DATA;
   logic       oLCD_RS;
   logic       oLCD_RW;
   logic       oLCD_E;

   modport master (
      output iREQ0, iREQ1, iRS0, iRS1, iDATA0, iDATA1,
      input  oACK0, oACK1, oREADY, oLCD_DATA, oLCD_RS, oLCD_RW, oLCD_E
   );

   modport slave (
      input  iREQ0, iREQ1, iRS0, iRS1, iDATA0, iDATA1,
      output oACK0, oACK1, oREADY, oLCD_DATA, oLCD_RS, oLCD_RW, oLCD_E
   );
endinterface

// File: rtl/lcd_write_arbiter.sv
// HD44780 bus sequencer with round-robin arbitration between two write ports.
// Define LCD_ARB_INIT_EN to build the power-up wait and the 0x38/0x0C/0x01/0x06 init sequence.
module lcd_write_arbiter #(
   parameter int unsigned T_PWRUP = 1000000,
   parameter int unsigned T_SETUP = 4,
   parameter int unsigned T_EN    = 16,
   parameter int unsigned T_HOLD  = 4,
   parameter int unsigned T_SHORT = 2500,
   parameter int unsigned T_LONG  = 100000
) (
   input logic                iCLK,
   input logic                iRST_N,
   lcd_write_arbiter_if.slave bus
);
   localparam int unsigned MaxA = (T_PWRUP > T_LONG) ? T_PWRUP : T_LONG;
   localparam int unsigned MaxB = (T_SHORT > T_EN) ? T_SHORT : T_EN;
   localparam int unsigned MaxC = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
   localparam int unsigned MaxAB = (MaxA > MaxB) ? MaxA : MaxB;
   localparam int unsigned TMax = (MaxAB > MaxC) ? MaxAB : MaxC;
   localparam int unsigned CntW = ($clog2(TMax) > 0) ? $clog2(TMax) : 1;

   typedef enum logic [2:0] {
`ifdef LCD_ARB_INIT_EN
      StPwrup,
      StInit,
`endif
      StIdle,
      StSetup,
      StPulse,
      StHold,
      StWait
   } state_e;

   state_e          r_state;
   logic [CntW-1:0] r_cnt;
   logic            r_prio;   // port favoured when both request
   logic            r_ready;
   logic            r_ack0;
   logic            r_ack1;
   logic            r_rs;
   logic [7:0]      r_data;
   logic            r_e;
   logic            w_gnt0;
   logic            w_gnt1;
   logic            w_long;

`ifdef LCD_ARB_INIT_EN
   logic [1:0] r_init_idx;
   logic [7:0] w_init_cmd;

   always_comb begin
      case (r_init_idx)
         2'd0:    w_init_cmd = 8'h38;
         2'd1:    w_init_cmd = 8'h0C;
         2'd2:    w_init_cmd = 8'h01;
         default: w_init_cmd = 8'h06;
      endcase
   end
`endif

   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (r_state == StIdle && r_ready) begin
         if (bus.iREQ0 && (!bus.iREQ1 || !r_prio)) w_gnt0 = 1'b1;
         else if (bus.iREQ1)                      w_gnt1 = 1'b1;
      end
   end

   // Clear and return-home need the long execution delay.
   assign w_long = !r_rs && (r_data inside {8'h01, 8'h02, 8'h03});

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
`ifdef LCD_ARB_INIT_EN
         r_state    <= StPwrup;
         r_cnt      <= CntW'(T_PWRUP - 1);
         r_init_idx <= 2'd0;
`else
         r_state    <= StIdle;
         r_cnt      <= '0;
`endif
         r_prio     <= 1'b0;
         r_ready    <= 1'b0;
         r_ack0     <= 1'b0;
         r_ack1     <= 1'b0;
         r_rs       <= 1'b0;
         r_data     <= 8'h00;
         r_e        <= 1'b0;
      end else begin
         r_ack0 <= 1'b0;
         r_ack1 <= 1'b0;
         case (r_state)
`ifdef LCD_ARB_INIT_EN
            StPwrup: begin
               if (r_cnt != '0) r_cnt <= r_cnt - CntW'(1);
               else             r_state <= StInit;
            end
            StInit: begin
               r_rs    <= 1'b0;
               r_data  <= w_init_cmd;
               r_cnt   <= CntW'(T_SETUP - 1);
               r_state <= StSetup;
            end
`endif
            StIdle: begin
               if (!r_ready) begin
                  r_ready <= 1'b1;
               end else if (w_gnt0 || w_gnt1) begin
                  r_ack0  <= w_gnt0;
                  r_ack1  <= w_gnt1;
                  r_rs    <= w_gnt1 ? bus.iRS1 : bus.iRS0;
                  r_data  <= w_gnt1 ? bus.iDATA1 : bus.iDATA0;
                  r_prio  <= w_gnt0;
                  r_cnt   <= CntW'(T_SETUP - 1);
                  r_state <= StSetup;
               end
            end
            StSetup: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CntW'(1);
               end else begin
                  r_e     <= 1'b1;
                  r_cnt   <= CntW'(T_EN - 1);
                  r_state <= StPulse;
               end
            end
            StPulse: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CntW'(1);
               end else begin
                  r_e     <= 1'b0;
                  r_cnt   <= CntW'(T_HOLD - 1);
                  r_state <= StHold;
               end
            end
            StHold: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CntW'(1);
               end else begin
                  r_cnt   <= w_long ? CntW'(T_LONG - 1) : CntW'(T_SHORT - 1);
                  r_state <= StWait;
               end
            end
            StWait: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CntW'(1);
               end else begin
`ifdef LCD_ARB_INIT_EN
                  if (r_ready) begin
                     r_state <= StIdle;
                  end else if (r_init_idx == 2'd3) begin
                     r_ready <= 1'b1;
                     r_state <= StIdle;
                  end else begin
                     r_init_idx <= r_init_idx + 2'd1;
                     r_state    <= StInit;
                  end
`else
                  r_state <= StIdle;
`endif
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign bus.oACK0     = r_ack0;
   assign bus.oACK1     = r_ack1;
   assign bus.oREADY    = r_ready;
   assign bus.oLCD_DATA = r_data;
   assign bus.oLCD_RS   = r_rs;
   assign bus.oLCD_RW   = 1'b0;
   assign bus.oLCD_E    = r_e;
endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Bench for lcd_write_arbiter: directed phases plus random two-port traffic,
// checked every cycle against a timeline model of grants, E pulses and waits.
`timescale 1ns/1ps
module tb_lcd_write_arbiter;
   localparam int TPwrup = 10;
   localparam int TSetup = 2;
   localparam int TEn    = 3;
   localparam int THold  = 2;
   localparam int TShort = 5;
   localparam int TLong  = 20;
   localparam int TBase  = 1 + TSetup + TEn + THold;
   localparam int Never  = 32'h3fff_ffff;
`ifdef LCD_ARB_INIT_EN
   localparam int FirstDec = 10 + 4 * 8 + 3 * 5 + 20;
`else
   localparam int FirstDec = 1;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   lcd_write_arbiter_if bus ();

   lcd_write_arbiter #(
      .T_PWRUP(TPwrup), .T_SETUP(TSetup), .T_EN(TEn),
      .T_HOLD(THold), .T_SHORT(TShort), .T_LONG(TLong)
   ) dut (
      .iCLK  (clk),
      .iRST_N(rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp_v);
      n_vec++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp_v);
      end
   endtask

   // Timeline model: a decision cycle n starts a write whose bus phase begins at n+1.
   int         m_next_dec = Never;
   int         m_ready_from = Never;
   int         m_s = 0;
   int         m_init_idx = 0;
   bit         m_has_txn = 0;
   bit         m_prio = 0;
   bit         m_in_reset = 1;
   bit         m_rs = 0;
   logic [7:0] m_data = 8'h00;
   bit         m_ack0 = 0;
   bit         m_ack1 = 0;
   logic [7:0] init_cmd [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

   int         rise_cyc [$];
   logic [7:0] rise_data [$];
   int         rise_rs [$];
   int         ack_log [$];
   bit         prev_e = 0;

   function automatic int wait_len(input bit rs, input logic [7:0] d);
      return (!rs && d >= 8'h01 && d <= 8'h03) ? TLong : TShort;
   endfunction

   function automatic void m_start(input int n, input bit rs, input logic [7:0] d);
      m_has_txn  = 1;
      m_s        = n + 1;
      m_rs       = rs;
      m_data     = d;
      m_next_dec = n + TBase + wait_len(rs, d);
   endfunction

   always @(negedge clk) begin : cmp
      int n;
      int g;
      bit exp_e;
      n = cyc;
      if (!rst_n) begin
         m_in_reset = 1; m_has_txn = 0; m_prio = 0; m_rs = 0; m_data = 8'h00;
         m_ack0 = 0; m_ack1 = 0; m_init_idx = 0;
         m_next_dec = Never; m_ready_from = Never;
      end else if (m_in_reset) begin
         m_in_reset = 0;
`ifdef LCD_ARB_INIT_EN
         m_next_dec = n + TPwrup;
`else
         m_next_dec   = n + 1;
         m_ready_from = n + 1;
`endif
      end
      exp_e = m_has_txn && n >= m_s + TSetup && n < m_s + TSetup + TEn;
      chk("lcd_e", bus.oLCD_E, exp_e);
      chk("lcd_rs", bus.oLCD_RS, m_rs);
      chk("lcd_data", bus.oLCD_DATA, m_data);
      chk("lcd_rw", bus.oLCD_RW, 0);
      chk("ready", bus.oREADY, n >= m_ready_from);
      chk("ack0", bus.oACK0, m_ack0);
      chk("ack1", bus.oACK1, m_ack1);
      chk("ack_excl", bus.oACK0 & bus.oACK1, 0);
      if (bus.oLCD_E && !prev_e) begin
         rise_cyc.push_back(n);
         rise_data.push_back(bus.oLCD_DATA);
         rise_rs.push_back(bus.oLCD_RS);
      end
      prev_e = bus.oLCD_E;
      if (bus.oACK0) ack_log.push_back(0);
      if (bus.oACK1) ack_log.push_back(1);

      m_ack0 = 0;
      m_ack1 = 0;
      if (rst_n && n == m_next_dec) begin
`ifdef LCD_ARB_INIT_EN
         if (m_init_idx < 4) begin
            m_start(n, 1'b0, init_cmd[m_init_idx]);
            m_init_idx++;
            if (m_init_idx == 4) m_ready_from = m_next_dec;
         end else
`endif
         if (n >= m_ready_from) begin
            g = -1;
            if (bus.iREQ0 && bus.iREQ1) g = int'(m_prio);
            else if (bus.iREQ0)         g = 0;
            else if (bus.iREQ1)         g = 1;
            if (g == 0) begin
               m_start(n, bus.iRS0, bus.iDATA0); m_ack0 = 1; m_prio = 1;
            end else if (g == 1) begin
               m_start(n, bus.iRS1, bus.iDATA1); m_ack1 = 1; m_prio = 0;
            end else begin
               m_next_dec = n + 1;
            end
         end
      end
   end

   task automatic wait_cyc(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rand_port(input int p);
      bit         free;
      bit         go;
      bit         rs;
      logic [7:0] d;
      free = (p == 0) ? (m_ack0 || !bus.iREQ0) : (m_ack1 || !bus.iREQ1);
      if (free) begin
         go = ($urandom_range(0, 2) == 0);
         rs = ($urandom_range(0, 1) != 0);
         d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
         if (p == 0) begin
            bus.iREQ0 = go; bus.iRS0 = rs; bus.iDATA0 = d;
         end else begin
            bus.iREQ1 = go; bus.iRS1 = rs; bus.iDATA1 = d;
         end
      end
   endtask

   task automatic check_init_replay();
`ifdef LCD_ARB_INIT_EN
      chk("init_rises", rise_cyc.size() >= 4, 1);
      for (int i = 0; i < 4; i++) begin
         if (i < rise_cyc.size()) begin
            chk("init_cmd", rise_data[i], init_cmd[i]);
            chk("init_rs", rise_rs[i], 0);
         end
      end
      if (rise_cyc.size() >= 4) begin
         chk("init_gap_short", rise_cyc[1] - rise_cyc[0], 13);
         chk("init_gap_long", rise_cyc[3] - rise_cyc[2], 28);
      end
`else
      chk("no_init_pulse", rise_cyc.size(), 0);
`endif
   endtask

   initial begin
      int  k;
      int  a2;
      bit  seen;
      bus.iREQ0 = 1'b1; bus.iRS0 = 1'b1; bus.iDATA0 = 8'h41;
      bus.iREQ1 = 1'b0; bus.iRS1 = 1'b0; bus.iDATA1 = 8'h00;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      k = cyc;

      // Port 0 request held from reset: served only once ready.
      wait_cyc(k + FirstDec - 1);
      chk("ready_before", bus.oREADY, 0);
      wait_cyc(k + FirstDec);
      chk("ready_after", bus.oREADY, 1);
      check_init_replay();
      wait_cyc(k + FirstDec + 1);
      chk("p0_ack", bus.oACK0, 1);
      chk("p0_rs", bus.oLCD_RS, 1);
      chk("p0_data", bus.oLCD_DATA, 8'h41);
      bus.iDATA0 = 8'h42;
      wait_cyc(k + FirstDec + 1 + TSetup);
      chk("p0_e_high", bus.oLCD_E, 1);
      wait_cyc(k + FirstDec + 1 + TSetup + TEn);
      chk("p0_e_low", bus.oLCD_E, 0);
      wait_cyc(k + FirstDec + 13);
      chk("p0_short_gap", bus.oACK0, 0);
      a2 = k + FirstDec + 14;
      wait_cyc(a2);
      chk("p0_ack2", bus.oACK0, 1);
      chk("p0_data2", bus.oLCD_DATA, 8'h42);

      // Port 1 commands: 0x02 needs the long wait, 0x80 the short one.
      bus.iREQ0 = 1'b0;
      bus.iREQ1 = 1'b1; bus.iRS1 = 1'b0; bus.iDATA1 = 8'h02;
      wait_cyc(a2 + 13);
      chk("p1_ack_home", bus.oACK1, 1);
      chk("p1_data_home", bus.oLCD_DATA, 8'h02);
      bus.iDATA1 = 8'h80;
      wait_cyc(a2 + 40);
      chk("p1_long_gap", bus.oACK1, 0);
      wait_cyc(a2 + 41);
      chk("p1_ack_80", bus.oACK1, 1);

      // Both held: grants alternate, starting with port 0.
      bus.iREQ0 = 1'b1; bus.iRS0 = 1'b1; bus.iDATA0 = 8'h30;
      bus.iRS1 = 1'b1; bus.iDATA1 = 8'h31;
      wait_cyc(a2 + 42);
      ack_log.delete();
      wait_cyc(a2 + 54);
      chk("rr_first_p0", bus.oACK0, 1);
      wait_cyc(a2 + 95);
      chk("rr_count", ack_log.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < ack_log.size()) chk("rr_seq", ack_log[i], i % 2);
      end

      for (int i = 0; i < 1500; i++) begin
         @(posedge clk);
         #1;
         rand_port(0);
         rand_port(1);
      end

      // Reset in the middle of an E pulse.
      seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(posedge clk);
         #1;
         rand_port(0);
         rand_port(1);
         if (bus.oLCD_E) seen = 1;
      end
      chk("e_seen_before_reset", seen, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_e", bus.oLCD_E, 0);
      chk("rst_rs", bus.oLCD_RS, 0);
      chk("rst_data", bus.oLCD_DATA, 0);
      chk("rst_ready", bus.oREADY, 0);
      chk("rst_acks", bus.oACK0 | bus.oACK1, 0);
      rise_cyc.delete(); rise_data.delete(); rise_rs.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      k = cyc;
      wait_cyc(k + FirstDec);
      chk("replay_ready", bus.oREADY, 1);
      check_init_replay();

      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #1;
         rand_port(0);
         rand_port(1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
